// File: rtl/uart_rx_drain_if.sv
// Bundles the RX-FIFO side, the control inputs, the outgoing byte stream and the
// interrupt outputs of the RX drain controller. The controller uses the master
// modport. The RX path and the consumer use the slave modport.
interface uart_rx_drain_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEVEL_WIDTH = 4
);
  logic                   sample_tick;
  logic                   fifo_reset;
  logic                   drain_en;
  logic [LEVEL_WIDTH-1:0] rx_thresh;
  logic                   rx_empty;
  logic [LEVEL_WIDTH-1:0] rx_level;
  logic [DATA_WIDTH-1:0]  rx_data;
  logic                   rx_active;
  logic                   frame_error;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   irq_thresh;
  logic                   irq_timeout;
  logic                   frame_err_sticky;

  modport master (
    input  sample_tick, fifo_reset, drain_en, rx_thresh,
    input  rx_empty, rx_level, rx_data, rx_active, frame_error,
    input  m_ready,
    output rd_en, m_data, m_valid,
    output irq_thresh, irq_timeout, frame_err_sticky
  );

  modport slave (
    output sample_tick, fifo_reset, drain_en, rx_thresh,
    output rx_empty, rx_level, rx_data, rx_active, frame_error,
    output m_ready,
    input  rd_en, m_data, m_valid,
    input  irq_thresh, irq_timeout, frame_err_sticky
  );
endinterface

// File: rtl/uart_rx_drain_ctrl.sv
// UART RX drain controller.
// Pops the first-word-fall-through RX FIFO one byte at a time and presents each
// byte on a valid/ready stream. The pop sequence is POP, GAP, HOLD. Because of
// this sequence, rd_en is a single-cycle pulse, and consecutive pops are at
// least three cycles apart. The module also raises the threshold interrupt, the
// character-timeout interrupt and a sticky frame-error flag.
module uart_rx_drain_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int LEVEL_WIDTH   = 4,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic            uart_clk,
  input  logic            rst_n,
  uart_rx_drain_if.master bus
);

  localparam int              CNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {IDLE, POP, GAP, HOLD} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic [CNT_W-1:0]       to_cnt;
  logic [CNT_W-1:0]       to_cnt_nxt;
  logic                   to_clr;
  logic                   irq_timeout_q;
  logic                   irq_timeout_nxt;
  logic                   irq_thresh_q;
  logic                   frame_err_q;
  logic [LEVEL_WIDTH-1:0] rx_level_p1;

  // Drain FSM state register
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and pop strobe; fifo_reset aborts any byte in flight and suppresses rd_en
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (bus.fifo_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.drain_en && !bus.rx_empty) state_nxt = POP;
        POP: begin
          pop       = 1'b1;
          state_nxt = GAP;
        end
        GAP:     state_nxt = HOLD;
        HOLD:    if (bus.m_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Capture the FIFO head word while it is being popped; hold it through GAP/HOLD
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n)   m_data_q <= '0;
    else if (pop) m_data_q <= bus.rx_data;
  end

  // Character-timeout counter next value and interrupt next value
  always_comb begin
    to_clr     = bus.rx_empty || bus.rx_active || pop || (bus.rx_level != rx_level_p1);
    to_cnt_nxt = to_cnt;
    if (to_clr)                                   to_cnt_nxt = '0;
    else if (bus.sample_tick && to_cnt != CNT_MAX) to_cnt_nxt = to_cnt + CNT_W'(1);
    irq_timeout_nxt = irq_timeout_q;
    if (pop || bus.rx_empty)        irq_timeout_nxt = 1'b0;
    else if (to_cnt_nxt == CNT_MAX) irq_timeout_nxt = 1'b1;
  end

  // Interrupt, flag and level-history registers; fifo_reset clears the timeout and error state
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt        <= '0;
      irq_timeout_q <= 1'b0;
      irq_thresh_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_level_p1   <= '0;
    end else begin
      rx_level_p1  <= bus.rx_level;
      irq_thresh_q <= (bus.rx_thresh != '0) && (bus.rx_level >= bus.rx_thresh);
      if (bus.fifo_reset) begin
        to_cnt        <= '0;
        irq_timeout_q <= 1'b0;
        frame_err_q   <= 1'b0;
      end else begin
        to_cnt        <= to_cnt_nxt;
        irq_timeout_q <= irq_timeout_nxt;
        frame_err_q   <= frame_err_q | bus.frame_error;
      end
    end
  end

  assign bus.rd_en            = pop;
  assign bus.m_valid          = (state == HOLD);
  assign bus.m_data           = m_data_q;
  assign bus.irq_thresh       = irq_thresh_q;
  assign bus.irq_timeout      = irq_timeout_q;
  assign bus.frame_err_sticky = frame_err_q;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Randomized bench for uart_rx_drain_ctrl. A queue plays the role of the RX FIFO.
// A transaction-level reference predicts the interrupts, the flag and the byte
// stream, in push order, on every cycle.
module tb_uart_rx_drain_ctrl;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int TT = 640;

  logic uart_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 uart_clk = ~uart_clk;

  uart_rx_drain_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) bus ();

  uart_rx_drain_ctrl #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .TIMEOUT_TICKS(TT)) dut (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // environment FIFO and push-order scoreboard
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] obs_q[$];

  // reference state
  bit            busy;
  int            age;
  logic [DW-1:0] e_byte;
  int            cnt;
  bit            e_irq, e_sticky, e_thr;
  logic [LW-1:0] lvl_prev;

  // stimulus knobs
  int p_push, max_lvl, p_ready, tick_period, p_act, p_fe, p_fr;
  bit de_k;
  int tick_ctr;

  int n_chk, n_fail, n_pops, cyc, last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic env_outputs();
    bus.rx_empty = (fq.size() == 0);
    bus.rx_level = LW'(fq.size());
    bus.rx_data  = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] b);
    fq.push_back(b);
    sb.push_back(b);
    env_outputs();
  endtask

  task automatic drive_random();
    if (fq.size() < max_lvl && $urandom_range(99) < p_push) push(DW'($urandom));
    bus.m_ready     = ($urandom_range(99) < p_ready);
    tick_ctr++;
    bus.sample_tick = (tick_ctr % tick_period == 0);
    bus.rx_active   = ($urandom_range(99) < p_act);
    bus.frame_error = ($urandom_range(999) < p_fe);
    bus.fifo_reset  = ($urandom_range(999) < p_fr);
    bus.drain_en    = de_k;
    env_outputs();
  endtask

  task automatic model_reset();
    busy = 0; age = 0; e_byte = '0; cnt = 0;
    e_irq = 0; e_sticky = 0; e_thr = 0; lvl_prev = '0;
  endtask

  // advance the reference across one rising edge using the inputs now applied
  task automatic model_update(input bit e_rd);
    bit            fr, emp;
    logic [LW-1:0] lvl;
    fr  = bus.fifo_reset;
    emp = bus.rx_empty;
    lvl = bus.rx_level;
    e_thr = (bus.rx_thresh != 0) && (lvl >= bus.rx_thresh);
    if (fr) begin
      e_sticky = 0; cnt = 0; e_irq = 0; busy = 0;
      sb.delete();
    end else begin
      if (bus.frame_error) e_sticky = 1;
      if (emp || bus.rx_active || e_rd || lvl != lvl_prev) cnt = 0;
      else if (bus.sample_tick && cnt < TT) cnt++;
      if (e_rd || emp)  e_irq = 0;
      else if (cnt == TT) e_irq = 1;
      if (busy) begin
        if (age == 0) begin
          e_byte = (sb.size() > 0) ? sb.pop_front() : '0;
          age = 1;
        end else if (age == 1) age = 2;
        else if (bus.m_ready) busy = 0;
      end else if (bus.drain_en && !emp) begin
        busy = 1; age = 0;
      end
    end
    lvl_prev = lvl;
  endtask

  task automatic cycle();
    bit fr, e_rd, e_vld, dut_rd;
    @(negedge uart_clk);
    cyc++;
    fr    = bus.fifo_reset;
    e_rd  = busy && age == 0 && !fr;
    e_vld = busy && age >= 2;
    chk("rd_en", bus.rd_en, e_rd);
    chk("m_valid", bus.m_valid, e_vld);
    if (e_vld) chk("m_data", bus.m_data, e_byte);
    chk("irq_thresh", bus.irq_thresh, e_thr);
    chk("irq_timeout", bus.irq_timeout, e_irq);
    chk("frame_err_sticky", bus.frame_err_sticky, e_sticky);
    dut_rd = bus.rd_en;
    if (dut_rd) begin
      if (last_rd >= 0) chk("rd_spacing_ge3", (cyc - last_rd) >= 3, 1);
      last_rd = cyc;
      n_pops++;
    end
    if (bus.m_valid && bus.m_ready) obs_q.push_back(bus.m_data);
    model_update(e_rd);
    @(posedge uart_clk);
    #1;
    if (fr) fq.delete();
    else if (dut_rd && fq.size() > 0) void'(fq.pop_front());
    drive_random();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic flush();
    bus.fifo_reset = 1'b1;
    cycle();
  endtask

  initial begin
    int p0;
    bit hit;
    n_chk = 0; n_fail = 0; n_pops = 0; cyc = 0; last_rd = -1; tick_ctr = 0;
    p_push = 0; max_lvl = 0; p_ready = 100; tick_period = 4;
    p_act = 0; p_fe = 0; p_fr = 0; de_k = 1;
    bus.sample_tick = 0; bus.fifo_reset = 0; bus.drain_en = 0; bus.rx_thresh = '0;
    bus.rx_active = 0; bus.frame_error = 0; bus.m_ready = 0;
    env_outputs();
    model_reset();

    // reset state
    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_irq_timeout", bus.irq_timeout, 0);
    chk("rst_frame_err", bus.frame_err_sticky, 0);
    @(posedge uart_clk); @(posedge uart_clk); #1;
    rst_n = 1'b1;
    drive_random();

    // T1: three bytes drain in order with ready held high
    push(8'hA5); push(8'h3C); push(8'hFF);
    run(20);
    chk("t1_pops", n_pops, 3);
    chk("t1_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("t1_byte0", obs_q[0], 8'hA5);
      chk("t1_byte1", obs_q[1], 8'h3C);
      chk("t1_byte2", obs_q[2], 8'hFF);
    end

    // T2: back-pressure holds the byte; next pop waits for the handshake
    p_ready = 0;
    p0 = n_pops;
    push(8'h11); push(8'h22);
    run(14);
    chk("t2_one_pop", n_pops - p0, 1);
    chk("t2_valid_held", bus.m_valid, 1);
    chk("t2_data_held", bus.m_data, 8'h11);
    p_ready = 100;
    run(10);
    chk("t2_two_pops", n_pops - p0, 2);

    // T3: threshold ramp with drain disabled, then threshold disabled
    de_k = 0; p_push = 100; max_lvl = 5;
    bus.rx_thresh = LW'(4);
    flush();
    run(8);
    chk("t3_thresh_hi", bus.irq_thresh, 1);
    bus.rx_thresh = '0;
    run(3);
    chk("t3_thresh_off", bus.irq_thresh, 0);

    // T4: idle FIFO with one byte reaches timeout; an rx_active pulse restarts it
    max_lvl = 1; tick_period = 1;
    flush();
    run(TT + 60);
    chk("t4_timeout", bus.irq_timeout, 1);
    flush();
    run(TT - 10);
    bus.rx_active = 1'b1;
    run(600);
    chk("t4_restart_no_irq", bus.irq_timeout, 0);
    run(60);
    chk("t4_timeout_again", bus.irq_timeout, 1);

    // T5: fifo_reset during GAP discards the byte and clears the flags
    max_lvl = 0; p_ready = 0; de_k = 1;
    bus.frame_error = 1'b1;
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      cycle();
      if (busy && age == 1) hit = 1;
    end
    chk("t5_reached_gap", hit, 1);
    bus.fifo_reset = 1'b1;
    cycle();
    chk("t5_sticky_clr", bus.frame_err_sticky, 0);
    chk("t5_irq_clr", bus.irq_timeout, 0);
    p0 = n_pops;
    run(10);
    chk("t5_no_valid", bus.m_valid, 0);
    chk("t5_no_pops", n_pops - p0, 0);

    // randomized mix of everything
    p_push = 40; max_lvl = 15; p_ready = 60; tick_period = 3;
    p_act = 10; p_fe = 5; p_fr = 3;
    for (int blk = 0; blk < 30; blk++) begin
      de_k = ($urandom_range(9) != 0);
      bus.rx_thresh = LW'($urandom_range(15));
      run(70);
    end

    // T6: asynchronous reset while holding a byte
    p_fr = 0; p_fe = 0; p_act = 0; p_ready = 0; de_k = 1; max_lvl = 1; p_push = 100;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cycle();
      if (busy && age >= 2) hit = 1;
    end
    chk("t6_reached_hold", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_en", bus.rd_en, 0);
    chk("t6_m_valid", bus.m_valid, 0);
    chk("t6_m_data", bus.m_data, 0);
    chk("t6_irq_thresh", bus.irq_thresh, 0);
    chk("t6_irq_timeout", bus.irq_timeout, 0);
    chk("t6_frame_err", bus.frame_err_sticky, 0);
    max_lvl = 0;
    fq.delete(); sb.delete();
    bus.rx_thresh = '0;
    env_outputs();
    model_reset();
    @(posedge uart_clk); #1;
    rst_n = 1'b1;
    p0 = n_pops;
    run(12);
    chk("t6_no_pops", n_pops - p0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
